// File: rtl/moment_pkg.sv
// Shared types and constants for the lattice moment RAM arbiter and its round-robin core.
package moment_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

    localparam int LATTICE_DEPTH = 256;
    localparam int MOMENT_WIDTH  = 32;

    localparam int PORT_WB   = 0;
    localparam int PORT_DISP = 1;
    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator. After any grant the priority pointer
// moves to the other port; with no grant it holds.
module rr_arb2
    import moment_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (&req_i) begin
                gnt_o[PORT_WB]   = ~prio_q;
                gnt_o[PORT_DISP] = prio_q;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // prio_q = 1 means the display port wins the next tie.
    always_comb begin
        prio_d = prio_q;
        if (gnt_o[PORT_WB]) begin
            prio_d = 1'b1;
        end else if (gnt_o[PORT_DISP]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/moment_ram_arbiter.sv
// Round-robin arbiter/sequencer for the single-port lattice moment RAM.
// Optional post-reset zero-fill sweep is built when MOMENT_ARB_CLEAR_EN is defined.
module moment_ram_arbiter
    import moment_pkg::*;
#(
    parameter int DEPTH         = LATTICE_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = MOMENT_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         ready_o,
    input  logic                         req0_i,
    input  logic                         req1_i,
    input  logic                         we0_i,
    input  logic                         we1_i,
    input  logic [ADDRESS_WIDTH-1:0]     addr0_i,
    input  logic [ADDRESS_WIDTH-1:0]     addr1_i,
    input  logic signed [DATA_WIDTH-1:0] wdata0_i,
    input  logic signed [DATA_WIDTH-1:0] wdata1_i,
    output logic                         gnt0_o,
    output logic                         gnt1_o,
    output logic signed [DATA_WIDTH-1:0] rdata_o,
    output logic                         rvalid0_o,
    output logic                         rvalid1_o,
    output logic [ADDRESS_WIDTH-1:0]     ram_address_o,
    output logic                         ram_we_o,
    output logic signed [DATA_WIDTH-1:0] ram_data_in_o,
    input  logic signed [DATA_WIDTH-1:0] ram_data_out_i
);

    logic                         ready_q;
    logic                         ready_d;
    logic                         clearing;
    logic [ADDRESS_WIDTH-1:0]     clr_addr;
    logic [NUM_PORTS-1:0]         req;
    logic [NUM_PORTS-1:0]         gnt;
    logic                         rd0;
    logic                         rd1;
    logic                         rvalid0_q;
    logic                         rvalid1_q;
    logic signed [DATA_WIDTH-1:0] rdata_q;
    logic signed [DATA_WIDTH-1:0] rdata_d;

`ifdef MOMENT_ARB_CLEAR_EN
    // state    | meaning
    // ST_CLEAR | zero-fill sweep, one word per cycle, requests held off
    // ST_SERVE | arbitrate requests, ready high
    arb_state_e               state_q;
    arb_state_e               state_d;
    logic [ADDRESS_WIDTH-1:0] clr_addr_q;
    logic [ADDRESS_WIDTH-1:0] clr_addr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == ADDRESS_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_SERVE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDRESS_WIDTH'(1);
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;
    assign ready_d  = (state_d == ST_SERVE);
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
    assign ready_d  = 1'b1;
`endif

    assign req[PORT_WB]   = req0_i;
    assign req[PORT_DISP] = req1_i;

    // ready_q is low in reset and throughout the sweep, so it doubles as the grant enable.
    rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ready_q),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign gnt0_o = gnt[PORT_WB];
    assign gnt1_o = gnt[PORT_DISP];

    always_comb begin
        ram_address_o = '0;
        ram_we_o      = 1'b0;
        ram_data_in_o = '0;
        if (clearing) begin
            ram_address_o = clr_addr;
            ram_we_o      = 1'b1;
        end else if (gnt[PORT_WB]) begin
            ram_address_o = addr0_i;
            ram_we_o      = we0_i;
            ram_data_in_o = wdata0_i;
        end else if (gnt[PORT_DISP]) begin
            ram_address_o = addr1_i;
            ram_we_o      = we1_i;
            ram_data_in_o = wdata1_i;
        end
    end

    assign rd0     = gnt[PORT_WB] & ~we0_i;
    assign rd1     = gnt[PORT_DISP] & ~we1_i;
    assign rdata_d = (rd0 | rd1) ? ram_data_out_i : rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q   <= ready_d;
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            rdata_q   <= rdata_d;
        end
    end

    assign ready_o   = ready_q;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_moment_ram_arbiter.sv
// Bench for moment_ram_arbiter: behavioural RAM + arbitration model checked every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
module tb_moment_ram_arbiter;

    localparam int DEPTH = moment_pkg::LATTICE_DEPTH;
    localparam int AW    = 8;
    localparam int DW    = 32;
`ifdef MOMENT_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam int READY_CYC = CLEAR_EN ? DEPTH : 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 ready_o;
    logic                 req0_i, req1_i, we0_i, we1_i;
    logic [AW-1:0]        addr0_i, addr1_i;
    logic signed [DW-1:0] wdata0_i, wdata1_i;
    logic                 gnt0_o, gnt1_o;
    logic signed [DW-1:0] rdata_o;
    logic                 rvalid0_o, rvalid1_o;
    logic [AW-1:0]        ram_address_o;
    logic                 ram_we_o;
    logic signed [DW-1:0] ram_data_in_o;
    logic signed [DW-1:0] ram_data_out_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    moment_ram_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ready_o        (ready_o),
        .req0_i         (req0_i),
        .req1_i         (req1_i),
        .we0_i          (we0_i),
        .we1_i          (we1_i),
        .addr0_i        (addr0_i),
        .addr1_i        (addr1_i),
        .wdata0_i       (wdata0_i),
        .wdata1_i       (wdata1_i),
        .gnt0_o         (gnt0_o),
        .gnt1_o         (gnt1_o),
        .rdata_o        (rdata_o),
        .rvalid0_o      (rvalid0_o),
        .rvalid1_o      (rvalid1_o),
        .ram_address_o  (ram_address_o),
        .ram_we_o       (ram_we_o),
        .ram_data_in_o  (ram_data_in_o),
        .ram_data_out_i (ram_data_out_i)
    );

    // The single-port RAM the arbiter drives: combinational read, write on the rising edge.
    logic signed [DW-1:0] ram_q [DEPTH];
    assign ram_data_out_i = ram_q[ram_address_o];
    always @(posedge clk_i) if (ram_we_o) ram_q[ram_address_o] <= ram_data_in_o;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the RAM must contain, who wins a tie next, and
    // what the read port must show, derived from the arbitration rules.
    logic signed [DW-1:0] mem_m [DEPTH];
    bit                   ready_m;
    int                   clr_idx_m;
    int                   tie_port_m;
    bit                   rv0_m, rv1_m;
    logic signed [DW-1:0] rdata_m;
    bit                   n_rv0, n_rv1, n_we;
    int                   n_tie;
    logic signed [DW-1:0] n_rdata, n_wdata;
    int                   n_waddr;
    bit                   g0_s, g1_s;

    task automatic model_reset();
        ready_m    = 1'b0;
        clr_idx_m  = 0;
        tie_port_m = 0;
        rv0_m      = 1'b0;
        rv1_m      = 1'b0;
        rdata_m    = '0;
    endtask

    always @(negedge clk_i) begin
        bit e_g0, e_g1, clr;
        if (rst_i) model_reset();
        clr  = CLEAR_EN && (clr_idx_m < DEPTH);
        e_g0 = ready_m && req0_i && (!req1_i || tie_port_m == 0);
        e_g1 = ready_m && req1_i && (!req0_i || tie_port_m == 1);
        check("ready", ready_o, ready_m);
        check("gnt0", gnt0_o, e_g0);
        check("gnt1", gnt1_o, e_g1);
        check("rvalid0", rvalid0_o, rv0_m);
        check("rvalid1", rvalid1_o, rv1_m);
        check("rdata", rdata_o, rdata_m);
        if (clr) begin
            check("clr_we", ram_we_o, 1);
            check("clr_addr", ram_address_o, clr_idx_m);
            check("clr_data", ram_data_in_o, 0);
        end else if (e_g0) begin
            check("p0_we", ram_we_o, we0_i);
            check("p0_addr", ram_address_o, addr0_i);
            check("p0_data", ram_data_in_o, wdata0_i);
        end else if (e_g1) begin
            check("p1_we", ram_we_o, we1_i);
            check("p1_addr", ram_address_o, addr1_i);
            check("p1_data", ram_data_in_o, wdata1_i);
        end else begin
            check("idle_we", ram_we_o, 0);
            check("idle_addr", ram_address_o, 0);
        end
        n_rv0   = e_g0 && !we0_i;
        n_rv1   = e_g1 && !we1_i;
        n_rdata = rdata_m;
        if (n_rv0) n_rdata = mem_m[addr0_i];
        if (n_rv1) n_rdata = mem_m[addr1_i];
        n_tie = tie_port_m;
        if (e_g0) n_tie = 1;
        if (e_g1) n_tie = 0;
        n_we    = 1'b0;
        n_waddr = 0;
        n_wdata = '0;
        if (clr) begin
            n_we = 1'b1; n_waddr = clr_idx_m;
        end else if (e_g0 && we0_i) begin
            n_we = 1'b1; n_waddr = int'(addr0_i); n_wdata = wdata0_i;
        end else if (e_g1 && we1_i) begin
            n_we = 1'b1; n_waddr = int'(addr1_i); n_wdata = wdata1_i;
        end
        g0_s = gnt0_o;
        g1_s = gnt1_o;
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            model_reset();
        end else begin
            if (n_we) mem_m[n_waddr] = n_wdata;
            rv0_m      = n_rv0;
            rv1_m      = n_rv1;
            rdata_m    = n_rdata;
            tie_port_m = n_tie;
            if (CLEAR_EN && clr_idx_m < DEPTH) begin
                clr_idx_m++;
                ready_m = (clr_idx_m == DEPTH);
            end else begin
                ready_m = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant with req dropped.
    task automatic access(input int port, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int waited);
        if (port == 0) begin
            req0_i = 1'b1; we0_i = we; addr0_i = a; wdata0_i = d;
        end else begin
            req1_i = 1'b1; we1_i = we; addr1_i = a; wdata1_i = d;
        end
        waited = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i);
            if ((port == 0 && gnt0_o) || (port == 1 && gnt1_o)) begin
                waited = k;
                break;
            end
        end
        if (waited < 0) check("grant_timeout", 0, 1);
        @(posedge clk_i); #1;
        if (port == 0) req0_i = 1'b0; else req1_i = 1'b0;
    endtask

    task automatic wait_ready(output int n, output logic [AW-1:0] first_addr);
        n = -1;
        first_addr = '1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i);
            if (k == 0) first_addr = ram_address_o;
            if (ready_o) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int            w, n;
        logic [AW-1:0] fa;
        int            seq [5];
        int            exp_seq [5];
        rst_i = 1'b1;
        req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_q[i] = $urandom;
            mem_m[i] = ram_q[i];
        end
        model_reset();

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", ready_o, 0);
        check("rst_gnt", {gnt1_o, gnt0_o}, 0);
        check("rst_rvalid", {rvalid1_o, rvalid0_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_addr", ram_address_o, 0);

        // Release reset with a write already pending on port 0.
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 8'd9; wdata0_i = 32'h0BADCAFE;
        wait_ready(n, fa);
        check("ready_cycle", n, READY_CYC);
        check("first_addr", fa, 0);
        check("pending_gnt0", gnt0_o, 1);
        @(posedge clk_i); #1;
        req0_i = 1'b0;

`ifdef MOMENT_ARB_CLEAR_EN
        access(1, 1'b0, 8'd200, 32'h0, w);
        @(negedge clk_i);
        check("clr_rd200_valid", rvalid1_o, 1);
        check("clr_rd200_data", rdata_o, 32'h0);
        @(posedge clk_i); #1;
`endif

        // Single read of a negative moment.
        access(0, 1'b1, 8'h37, 32'hFFFFFF9C, w);
        access(1, 1'b0, 8'h37, 32'h0, w);
        check("rd_gnt_latency", w, 0);
        @(negedge clk_i);
        check("rd37_valid1", rvalid1_o, 1);
        check("rd37_valid0", rvalid0_o, 0);
        check("rd37_data", rdata_o, 32'hFFFFFF9C);
        @(posedge clk_i); #1;

        // Write on port 0 then read on port 1 in the very next cycle.
        access(0, 1'b1, 8'd5, 32'h12345678, w);
        access(1, 1'b0, 8'd5, 32'h0, w);
        @(negedge clk_i);
        check("raw_valid1", rvalid1_o, 1);
        check("raw_data", rdata_o, 32'h12345678);
        @(posedge clk_i); #1;

        // Contention: both held; last slot shows where the pointer ended.
        exp_seq = '{0, 1, 0, 1, 0};
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 8'h37;
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            seq[i] = gnt0_o ? 0 : (gnt1_o ? 1 : 9);
            @(posedge clk_i); #1;
        end
        req0_i = 1'b0; req1_i = 1'b0;
        for (int i = 0; i < 5; i++) check($sformatf("contend_%0d", i), seq[i], exp_seq[i]);

        // Random traffic; a request is held until granted.
        for (int c = 0; c < 1500; c++) begin
            if (!req0_i || g0_s) begin
                req0_i   = ($urandom_range(0, 99) < 55);
                we0_i    = 1'($urandom_range(0, 1));
                addr0_i  = AW'($urandom_range(0, 15));
                wdata0_i = $urandom;
            end
            if (!req1_i || g1_s) begin
                req1_i   = ($urandom_range(0, 99) < 55);
                we1_i    = 1'($urandom_range(0, 1));
                addr1_i  = AW'($urandom_range(0, 15));
                wdata1_i = $urandom;
            end
            @(posedge clk_i); #1;
        end
        for (int c = 0; c < 10; c++) begin
            if (g0_s) req0_i = 1'b0;
            if (g1_s) req1_i = 1'b0;
            if (!req0_i && !req1_i) break;
            @(posedge clk_i); #1;
        end
        check("drain", {req1_i, req0_i}, 0);

        // Reset in the middle of a read: no rvalid may follow.
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 8'h37;
        @(negedge clk_i);
        check("xfer_gnt1", gnt1_o, 1);
        #1;
        rst_i = 1'b1;
        req1_i = 1'b0;
        @(negedge clk_i);
        check("xfer_rvalid1", rvalid1_o, 0);
        check("xfer_rdata", rdata_o, 0);
        check("xfer_ready", ready_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wait_ready(n, fa);
        check("xfer_ready_cycle", n, READY_CYC);
        check("xfer_first_addr", fa, 0);

`ifdef MOMENT_ARB_CLEAR_EN
        // Reset at clr_addr = 100: sweep restarts from 0 and runs a full DEPTH cycles.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("midclr_addr100", ram_address_o, 100);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wait_ready(n, fa);
        check("midclr_ready_cycle", n, DEPTH);
        check("midclr_restart_addr", fa, 0);
`endif

        @(posedge clk_i); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moment_ram_arbiter.md
# moment_ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port lattice moment RAM (16×16 cells, 32-bit signed moments, combinational read, write on rising clock edge). It sits between the RAM and two requesters: port 0 is the collision/stream write-back engine and port 1 is the display/readout scanner. It grants at most one access per cycle and registers read data toward the winner. When configured, it also runs a post-reset zero-fill sweep of the whole RAM.

## Interface
Parameters:
- DEPTH, 256, number of lattice cells (RAM words)
- ADDRESS_WIDTH, $clog2(DEPTH), RAM address width
- DATA_WIDTH, 32, moment word width (signed)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- ready  out  1  high when the arbiter is in SERVE
- req0 / req1  in  1  access request; held stable until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDRESS_WIDTH  cell address
- wdata0 / wdata1  in  DATA_WIDTH signed  write data
- gnt0 / gnt1  out  1  combinational grant; the access happens in this cycle
- rdata  out  DATA_WIDTH signed  registered read data
- rvalid0 / rvalid1  out  1  rdata is valid for that port (one-cycle pulse)
- ram_address  out  ADDRESS_WIDTH  to RAM address
- ram_WE  out  1  to RAM WE
- ram_data_in  out  DATA_WIDTH signed  to RAM data_in
- ram_data_out  in  DATA_WIDTH signed  from RAM data_out (combinational)

## Operation
- States: CLEAR, SERVE. Reset enters CLEAR when the clear feature is compiled in, otherwise SERVE.
- CLEAR:
  - Counter clr_addr runs 0..DEPTH-1, one word per cycle.
  - Drives ram_WE=1, ram_address=clr_addr, ram_data_in=0.
  - gnt0 = gnt1 = 0 and ready = 0. Requests are ignored but stay pending.
  - After the write at DEPTH-1, the next state is SERVE. There is no wrap.
- SERVE:
  - ready = 1.
  - Only req0 high: gnt0 = 1. Only req1 high: gnt1 = 1.
  - Both high: grant the port selected by priority pointer `prio`.
  - gnt is high only while the matching req is high.
- Pointer update: after any grant, `prio` points to the other port. With no grant it holds. Reset value is 0, so port 0 wins the first tie.
- RAM mux: the granted port drives address, WE (weN) and data. With no grant, ram_WE = 0 and ram_address holds 0.
- Read grant: rdata <= ram_data_out and rvalidN <= 1 at the clock edge. Otherwise rvalid0/1 <= 0 and rdata holds.
- Write grant: the RAM writes at the same edge. There is no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data. This follows from the RAM's combinational read.

## Timing
- Reset values:
  - Outputs: ready 0, gnt0/gnt1 0, rdata 0, rvalid0/1 0, ram_WE 0 (in SERVE), ram_address 0.
  - Internal: prio 0, clr_addr 0.
- Grant latency: 0 cycles (combinational from req and prio).
- Read latency: rvalid and rdata appear 1 cycle after the grant cycle.
- Worst-case wait under contention: 1 cycle.
- Clear duration: exactly DEPTH cycles after Reset deasserts. ready rises on cycle DEPTH.
- Reset asserted mid-CLEAR or mid-transfer: state, counter, pointer and registered outputs return to reset values immediately. The clear sweep restarts from address 0. An in-flight read produces no rvalid.
- A requester must not drop req before gnt. The arbiter keeps no request memory.

## Configuration
- Macro: MOMENT_ARB_CLEAR_EN.
- Defined: the CLEAR state and clr_addr counter are built. The RAM is all-zero when ready first rises.
- Undefined: no CLEAR logic. SERVE starts on the first edge after reset, so ready = 1 from then on and RAM contents are undefined.

## Structure
- Shared package moment_pkg holds:
  - arbiter state typedef (CLEAR, SERVE)
  - LATTICE_DEPTH = 256
  - MOMENT_WIDTH = 32
  - port index constants (PORT_WB = 0, PORT_DISP = 1)
- One natural sub-module: rr_arb2, a pure 2-way round-robin grant generator with a priority flip-flop. The top level adds the FSM, clear counter, RAM mux and read register.

## Test plan
- Clear sweep (macro on): release Reset, then observe 256 writes of 0 to addresses 0..255. ready rises on cycle 256 and a read of addr 200 returns rdata = 0.
- Single read: port 1 reads addr 0x37 holding 0xFFFFFF9C. gnt1 is high in the request cycle, and the next cycle shows rvalid1 = 1 with rdata = -100.
- Contention: req0 and req1 are held high for 4 cycles. Grants go 0,1,0,1 and prio ends at 0.
- Write then read: port 0 writes 0x12345678 to addr 5, then port 1 reads addr 5 in the next cycle. rdata = 0x12345678 and rvalid1 = 1.
- Reset mid-clear: assert Reset at clr_addr = 100, release it, then observe the sweep restart at address 0 and ready rise 256 cycles later.
- Macro off: ready = 1 on the first edge after reset. A req0 write lands on the first cycle.
